phys_reg_free_list: RTL

Physical-register free list for the rename stage.
- Rename side: supplies a free physical tag for each renamed destination register.
- Commit side: returns the superseded physical tag of each committing instruction.
- Keeps a retire-head pointer so that a pipeline flush reclaims every tag allocated by squashed instructions in one cycle.

---
 rtl/phys_reg_free_list_pkg.sv | 21 ++
 rtl/phys_reg_free_list_if.sv | 23 ++
 rtl/phys_reg_free_list_ring.sv | 33 +++
 rtl/phys_reg_free_list.sv | 91 +++++++++
 4 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package phys_reg_free_list_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int TAG_W         = $clog2(NUM_PHYS_REGS);
  localparam int PTR_W         = $clog2(FL_DEPTH) + 1;
  localparam int IDX_W         = PTR_W - 1;

  // Physical tag, also used by the rename map table.
  typedef logic [TAG_W-1:0] PhysReg;

  // Free-list pointer: MSB is the wrap bit, the rest index the ring.
  typedef logic [PTR_W-1:0] fl_ptr_t;

  function automatic logic [IDX_W-1:0] ptr_idx(input fl_ptr_t p);
    return p[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit/flush bundle between the pipeline and the free list.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic    alloc_req;
  logic    alloc_ready;
  PhysReg  alloc_tag;
  logic    commit_valid;
  PhysReg  commit_old_tag;
  logic    flush;
  fl_ptr_t free_count;
  logic    overflow_err;

  modport master (
    output alloc_req, commit_valid, commit_old_tag, flush,
    input  alloc_ready, alloc_tag, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_tag, flush,
    output alloc_ready, alloc_tag, free_count, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list_ring.sv
// Circular tag store: one write port, one combinational read port.
// Entry i resets to RESET_BASE + i so the list starts full of unmapped tags.
module free_list_ring #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 6,
  parameter int RESET_BASE = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Reload the initial tag set on reset; otherwise write the released tag.
  // NOTE: this array is reset on purpose -- its reset contents are the free
  // tags, so it must be flops rather than an unreset RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= WIDTH'(RESET_BASE + i);
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: zero-latency allocation at head, release at
// tail on commit, and single-cycle flush recovery via the retire-head pointer.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  phys_reg_free_list_if.slave bus
);

  localparam fl_ptr_t DEPTH_PTR = fl_ptr_t'(FL_DEPTH);
  localparam fl_ptr_t ONE_PTR   = fl_ptr_t'(1);

  fl_ptr_t r_head, r_retire_head, r_tail, r_free_count;
  logic    r_overflow_err;

  fl_ptr_t w_head_nxt, w_retire_nxt, w_tail_nxt;
  logic    w_alloc_ready, w_alloc_fire, w_full, w_commit_fire, w_overflow_set;
  PhysReg  w_head_tag;

  // Ready comes from registered pointers only, so a same-cycle release can
  // never be handed straight back out through an empty list.
  assign w_alloc_ready = (r_head != r_tail);
  assign w_alloc_fire  = bus.alloc_req && w_alloc_ready && !bus.flush;

  // A release into a list that already holds every spare tag is a protocol
  // bug. tail and retire_head always advance together, so fullness is judged
  // against head (tail - head == DEPTH).
  assign w_full         = ((r_tail - r_head) == DEPTH_PTR);
  assign w_commit_fire  = bus.commit_valid && !w_full;
  assign w_overflow_set = bus.commit_valid && w_full;

  // Next-pointer selection: commit first, then flush rewinds head to the
  // post-commit retire head, otherwise allocation advances head.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_tail_nxt   = r_tail;
    w_retire_nxt = r_retire_head;
    w_head_nxt   = r_head;
    if (w_commit_fire) begin
      w_tail_nxt   = r_tail + ONE_PTR;
      w_retire_nxt = r_retire_head + ONE_PTR;
    end
    if (bus.flush) begin
      w_head_nxt = w_retire_nxt;
    end else if (w_alloc_fire) begin
      w_head_nxt = r_head + ONE_PTR;
    end
  end

  // Pointer, count and sticky error registers.
  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head         <= '0;
      r_retire_head  <= '0;
      r_tail         <= DEPTH_PTR;
      r_free_count   <= DEPTH_PTR;
      r_overflow_err <= 1'b0;
    end else begin
      r_head        <= w_head_nxt;
      r_retire_head <= w_retire_nxt;
      r_tail        <= w_tail_nxt;
      r_free_count  <= w_tail_nxt - w_head_nxt;
      if (w_overflow_set) r_overflow_err <= 1'b1;
    end
  end

  free_list_ring #(
    .DEPTH     (FL_DEPTH),
    .WIDTH     (TAG_W),
    .RESET_BASE(NUM_ARCH_REGS),
    .IDX_W     (IDX_W)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit_fire),
    .i_waddr (ptr_idx(r_tail)),
    .i_wdata (bus.commit_old_tag),
    .i_raddr (ptr_idx(r_head)),
    .o_rdata (w_head_tag)
  );

  assign bus.alloc_ready  = w_alloc_ready;
  assign bus.alloc_tag    = w_head_tag;
  assign bus.free_count   = r_free_count;
  assign bus.overflow_err = r_overflow_err;

endmodule
